// File: rtl/player_bomb_ctrl.sv
// Player movement and single-bomb controller for a grid game.
// Ports: CLK/RESET, move/drop pulses in; player, bomb, blast, death state out.
module player_bomb_ctrl #(
    parameter int GRID_W      = 15,
    parameter int GRID_H      = 11,
    parameter int TICK_DIV    = 25000000,
    parameter int FUSE_TICKS  = 3,
    parameter int BLAST_TICKS = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       Up_SCEN,
    input  logic       Down_SCEN,
    input  logic       Left_SCEN,
    input  logic       Right_SCEN,
    input  logic       Middle_SCEN,
    output logic [3:0] player_x,
    output logic [3:0] player_y,
    output logic       bomb_active,
    output logic [3:0] bomb_x,
    output logic [3:0] bomb_y,
    output logic       blast_active,
    output logic       player_dead
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_BLAST = 2'd2;

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] FUSE_LAST  = TW'(FUSE_TICKS - 1);
    localparam logic [TW-1:0] BLAST_LAST = TW'(BLAST_TICKS - 1);
    localparam logic [3:0]    X_LAST     = 4'(GRID_W - 1);
    localparam logic [3:0]    Y_LAST     = 4'(GRID_H - 1);

    logic [3:0]    px_q, px_d;
    logic [3:0]    py_q, py_d;
    logic [3:0]    bx_q, bx_d;
    logic [3:0]    by_q, by_d;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          dead_q, dead_d;

    logic       up_req, dn_req, lf_req, rt_req;
    logic [3:0] tx, ty;
    logic       tgt_ok, on_bomb, pillar, move_ok;
    logic [3:0] dx, dy;
    logic       in_blast, tick;

    // Make the pulses one-hot so only the highest-priority move is decoded.
    always_comb begin
        up_req = Up_SCEN;
        dn_req = Down_SCEN & ~Up_SCEN;
        lf_req = Left_SCEN & ~Up_SCEN & ~Down_SCEN;
        rt_req = Right_SCEN & ~Up_SCEN & ~Down_SCEN & ~Left_SCEN;
    end

    // Range is checked on the current position, so no wrap can slip through.
    always_comb begin
        tx     = px_q;
        ty     = py_q;
        tgt_ok = 1'b0;
        unique case (1'b1)
            up_req: begin
                tgt_ok = (py_q != 4'd0);
                ty     = py_q - 4'd1;
            end
            dn_req: begin
                tgt_ok = (py_q < Y_LAST);
                ty     = py_q + 4'd1;
            end
            lf_req: begin
                tgt_ok = (px_q != 4'd0);
                tx     = px_q - 4'd1;
            end
            rt_req: begin
                tgt_ok = (px_q < X_LAST);
                tx     = px_q + 4'd1;
            end
            default: ;
        endcase
    end

    // Only entering the bomb tile is blocked, so a player on it can step off.
    always_comb begin
        pillar  = tx[0] & ty[0];
        on_bomb = (state_q != S_IDLE) && (tx == bx_q) && (ty == by_q);
        move_ok = tgt_ok & ~pillar & ~on_bomb & ~dead_q;
        px_d    = move_ok ? tx : px_q;
        py_d    = move_ok ? ty : py_q;
    end

    // The player never stands on a pillar or off-grid, so a plus-shape
    // distance test already excludes those tiles from the blast region.
    always_comb begin
        dx       = (px_q >= bx_q) ? (px_q - bx_q) : (bx_q - px_q);
        dy       = (py_q >= by_q) ? (py_q - by_q) : (by_q - py_q);
        in_blast = ((dx == 4'd0) && (dy <= 4'd1)) ||
                   ((dy == 4'd0) && (dx <= 4'd1));
    end

    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        tick_d  = tick_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dead_d  = dead_q;
        unique case (state_q)
            S_IDLE: begin
                pre_d  = '0;
                tick_d = '0;
                // Bomb latches the pre-move position.
                if (Middle_SCEN && !dead_q) begin
                    state_d = S_ARMED;
                    bx_d    = px_q;
                    by_d    = py_q;
                end
            end
            S_ARMED: begin
                pre_d = tick ? '0 : pre_q + PW'(1);
                if (tick) begin
                    if (tick_q == FUSE_LAST) begin
                        state_d = S_BLAST;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            S_BLAST: begin
                dead_d = dead_q | in_blast;
                pre_d  = tick ? '0 : pre_q + PW'(1);
                if (tick) begin
                    if (tick_q == BLAST_LAST) begin
                        state_d = S_IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                pre_d   = '0;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            px_q    <= '0;
            py_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            state_q <= S_IDLE;
            pre_q   <= '0;
            tick_q  <= '0;
            dead_q  <= 1'b0;
        end else begin
            px_q    <= px_d;
            py_q    <= py_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            state_q <= state_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            dead_q  <= dead_d;
        end
    end

    assign player_x     = px_q;
    assign player_y     = py_q;
    assign bomb_x       = bx_q;
    assign bomb_y       = by_q;
    assign bomb_active  = (state_q == S_ARMED);
    assign blast_active = (state_q == S_BLAST);
    assign player_dead  = dead_q;

endmodule

// File: tb/tb_player_bomb_ctrl.sv
// Self-checking bench for player_bomb_ctrl.
// Table of move vectors plus hand-written bomb/reset sequences.
module tb_player_bomb_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       Up_SCEN, Down_SCEN, Left_SCEN, Right_SCEN, Middle_SCEN;
    logic [3:0] player_x, player_y, bomb_x, bomb_y;
    logic       bomb_active, blast_active, player_dead;

    player_bomb_ctrl #(
        .GRID_W(15), .GRID_H(11), .TICK_DIV(4),
        .FUSE_TICKS(3), .BLAST_TICKS(2)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .Up_SCEN(Up_SCEN), .Down_SCEN(Down_SCEN),
        .Left_SCEN(Left_SCEN), .Right_SCEN(Right_SCEN),
        .Middle_SCEN(Middle_SCEN),
        .player_x(player_x), .player_y(player_y),
        .bomb_active(bomb_active), .bomb_x(bomb_x), .bomb_y(bomb_y),
        .blast_active(blast_active), .player_dead(player_dead)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] px;
        logic [3:0] py;
        logic       ba;
        logic [3:0] bx;
        logic [3:0] by;
        logic       bl;
        logic       dead;
    } out_t;

    typedef struct {
        logic [4:0] in;
        out_t       exp;
    } vec_t;

    localparam logic [4:0] U = 5'b10000;
    localparam logic [4:0] D = 5'b01000;
    localparam logic [4:0] L = 5'b00100;
    localparam logic [4:0] R = 5'b00010;
    localparam logic [4:0] M = 5'b00001;
    localparam logic [4:0] N = 5'b00000;

    out_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [3:0] ex, ey, ebx, eby;
    logic       eba, ebl, ed;

    function automatic out_t mk(input logic [3:0] px, py,
                                input logic ba,
                                input logic [3:0] bx, by,
                                input logic bl, dead);
        out_t o;
        o.px = px; o.py = py; o.ba = ba;
        o.bx = bx; o.by = by; o.bl = bl; o.dead = dead;
        return o;
    endfunction

    task automatic compare(input string nm);
        out_t e, a;
        e = sb_q.pop_front();
        a = mk(player_x, player_y, bomb_active, bomb_x, bomb_y,
               blast_active, player_dead);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got px=%0d py=%0d ba=%0b bx=%0d by=%0d bl=%0b dead=%0b, want px=%0d py=%0d ba=%0b bx=%0d by=%0d bl=%0b dead=%0b",
                     nm, a.px, a.py, a.ba, a.bx, a.by, a.bl, a.dead,
                     e.px, e.py, e.ba, e.bx, e.by, e.bl, e.dead);
        end
    endtask

    task automatic step(input logic [4:0] in, input out_t exp,
                        input string nm);
        {Up_SCEN, Down_SCEN, Left_SCEN, Right_SCEN, Middle_SCEN} = in;
        sb_q.push_back(exp);
        @(posedge CLK);
        #1;
        {Up_SCEN, Down_SCEN, Left_SCEN, Right_SCEN, Middle_SCEN} = N;
        compare(nm);
    endtask

    task automatic st(input logic [4:0] in, input string nm);
        step(in, mk(ex, ey, eba, ebx, eby, ebl, ed), nm);
    endtask

    task automatic check_now(input string nm);
        sb_q.push_back(mk(ex, ey, eba, ebx, eby, ebl, ed));
        compare(nm);
    endtask

    task automatic zero_exp();
        ex = 0; ey = 0; eba = 0; ebx = 0; eby = 0; ebl = 0; ed = 0;
    endtask

    vec_t tbl[15];

    initial begin
        RESET = 1'b0;
        {Up_SCEN, Down_SCEN, Left_SCEN, Right_SCEN, Middle_SCEN} = N;
        zero_exp();

        tbl[0]  = '{R,         mk(1, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{R,         mk(2, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{D,         mk(2, 1, 0, 0, 0, 0, 0)};
        tbl[3]  = '{L,         mk(2, 1, 0, 0, 0, 0, 0)};
        tbl[4]  = '{D,         mk(2, 2, 0, 0, 0, 0, 0)};
        tbl[5]  = '{U | L | R, mk(2, 1, 0, 0, 0, 0, 0)};
        tbl[6]  = '{U,         mk(2, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{L,         mk(1, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{D,         mk(1, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{L,         mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{L,         mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[11] = '{U,         mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[12] = '{D | R,     mk(0, 1, 0, 0, 0, 0, 0)};
        tbl[13] = '{U | D,     mk(0, 0, 0, 0, 0, 0, 0)};
        tbl[14] = '{L | R,     mk(0, 0, 0, 0, 0, 0, 0)};

        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_now("reset_state");
        RESET = 1'b1;

        for (int i = 0; i < 15; i++)
            step(tbl[i].in, tbl[i].exp, $sformatf("move_tbl[%0d]", i));

        for (int i = 0; i < 14; i++) begin
            ex = ex + 4'd1;
            st(R, "walk_right");
        end
        st(R, "right_edge");
        st(U, "top_edge");
        for (int i = 0; i < 12; i++) begin
            ex = ex - 4'd1;
            st(L, "walk_left");
        end

        // drop with same-cycle move, player escapes
        ex = 3; eba = 1; ebx = 2; eby = 0;
        st(R | M, "drop_and_move");
        st(L, "bomb_tile_blocked");
        ex = 4; st(R, "escape1");
        ex = 5; st(R, "escape2");
        for (int i = 0; i < 8; i++) st(N, "fuse_a");
        eba = 0; ebl = 1;
        for (int i = 0; i < 8; i++) st(N, "blast_a");
        ebl = 0;
        st(N, "idle_after_a");

        // player stays on bomb and dies
        for (int i = 0; i < 3; i++) begin
            ex = ex - 4'd1;
            st(L, "walk_back");
        end
        eba = 1; ebx = 2; eby = 0;
        st(M, "drop_stay");
        for (int i = 0; i < 11; i++) st(N, "fuse_b");
        eba = 0; ebl = 1;
        st(N, "blast_b_first");
        ed = 1;
        for (int i = 0; i < 7; i++) st(N, "blast_b_dead");
        ebl = 0;
        st(N, "dead_sticky");
        st(R, "dead_move_ignored");
        st(M, "dead_drop_ignored");
        st(D, "dead_down_ignored");

        RESET = 1'b0;
        zero_exp();
        #1;
        check_now("reset_clears_dead");
        st(R, "reset_held");
        RESET = 1'b1;

        // bomb at (4,0): leave tile, blocked return, second drop ignored
        for (int i = 0; i < 4; i++) begin
            ex = ex + 4'd1;
            st(R, "walk_to_4");
        end
        eba = 1; ebx = 4; eby = 0;
        st(M, "drop_at_4");
        ex = 3; st(L, "leave_bomb_tile");
        st(R, "right_blocked_armed");
        st(M, "second_drop_ignored");
        ex = 2; st(L, "retreat1");
        ex = 1; st(L, "retreat2");
        for (int i = 0; i < 6; i++) st(N, "fuse_c");
        eba = 0; ebl = 1;
        for (int i = 0; i < 8; i++) st(N, "blast_c");
        ebl = 0;
        st(N, "idle_after_c");

        // reset in the middle of the fuse aborts the bomb
        eba = 1; ebx = 1; eby = 0;
        st(M, "drop_d");
        for (int i = 0; i < 4; i++) st(N, "fuse_d");
        RESET = 1'b0;
        zero_exp();
        #1;
        check_now("reset_mid_armed");
        st(R, "reset_held_d");
        RESET = 1'b1;
        ex = 1;
        st(R, "first_edge_after_reset");
        for (int i = 0; i < 30; i++) st(N, "no_blast_after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
